// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Shares one word-addressed external bus between the CPU core (master 0) and a
// DMA/video requester (master 1). The CPU owns the bus by default; the DMA is
// given bounded bursts, each preceded by one idle HANDOVER cycle. After a DMA
// grant ends the CPU keeps the bus for CPU_MIN_GAP cycles before the DMA can be
// granted again.
//
// Ports:
//   clock_i, reset_ni          clock (rising edge), async active-low reset
//   cpu_*_i / cpu_*_o          CPU bus interface (address, data, strobes,
//                              read/write requests, read data, stall)
//   dma_*_i / dma_*_o          DMA interface (level request, beat info,
//                              grant, per-beat ack, read data)
//   bus_*_o / bus_data_in_i    external bus pins
//   owner_o                    0 = CPU, 1 = DMA
// The bus path is a pure combinational mux selected by the registered state.
// -----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int DMA_MAX_BURST = 4,
    parameter int CPU_MIN_GAP   = 2
) (
    input  logic        clock_i,
    input  logic        reset_ni,
    input  logic [29:0] cpu_address_i,
    input  logic [31:0] cpu_data_out_i,
    input  logic [3:0]  cpu_data_strobes_i,
    input  logic        cpu_read_i,
    input  logic        cpu_write_i,
    output logic [31:0] cpu_data_in_o,
    output logic        cpu_stall_o,
    input  logic        dma_req_i,
    input  logic [29:0] dma_address_i,
    input  logic [31:0] dma_data_out_i,
    input  logic [3:0]  dma_data_strobes_i,
    input  logic        dma_write_i,
    input  logic        dma_last_i,
    output logic        dma_grant_o,
    output logic        dma_ack_o,
    output logic [31:0] dma_data_in_o,
    output logic [29:0] bus_address_o,
    output logic [31:0] bus_data_out_o,
    output logic [3:0]  bus_data_strobes_o,
    output logic        bus_read_o,
    output logic        bus_write_o,
    input  logic [31:0] bus_data_in_i,
    output logic        owner_o
);

    localparam int BW = $clog2(DMA_MAX_BURST + 1);
    localparam int GW = (CPU_MIN_GAP > 0) ? $clog2(CPU_MIN_GAP + 1) : 1;

    typedef enum logic [1:0] {
        CPU_OWN  = 2'd0,
        HANDOVER = 2'd1,
        DMA_OWN  = 2'd2
    } state_t;

    state_t          state_q;
    logic [BW-1:0]   beat_q;
    logic [BW-1:0]   beat_d;
    logic [GW-1:0]   gap_q;
    logic [GW-1:0]   gap_d;
    logic            stall_q;
    logic            grant_q;
    logic            owner_q;

    // Saturating decrement of the gap counter; the DMA may leave CPU_OWN on
    // the edge where this reaches zero, so exactly CPU_MIN_GAP CPU cycles
    // separate two grants (the first CPU cycle after an exit is unavoidable,
    // so CPU_MIN_GAP of 0 and 1 behave alike).
    assign gap_d  = (gap_q != '0) ? gap_q - 1'b1 : '0;
    assign beat_d = beat_q + 1'b1;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= CPU_OWN;
            beat_q  <= '0;
            gap_q   <= '0;
            stall_q <= 1'b0;
            grant_q <= 1'b0;
            owner_q <= 1'b0;
        end else begin
            case (state_q)
                CPU_OWN: begin
                    gap_q <= gap_d;
                    if (dma_req_i && (gap_d == '0)) begin
                        state_q <= HANDOVER;
                        stall_q <= 1'b1;
                    end
                end
                HANDOVER: begin
                    beat_q <= '0;
                    if (dma_req_i) begin
                        state_q <= DMA_OWN;
                        grant_q <= 1'b1;
                        owner_q <= 1'b1;
                    end else begin
                        state_q <= CPU_OWN;
                        stall_q <= 1'b0;
                    end
                end
                DMA_OWN: begin
                    if (dma_req_i) begin
                        beat_q <= beat_d;
                    end
                    // Exit on an idle cycle, a last beat, or a full burst.
                    if (!dma_req_i || dma_last_i ||
                        (beat_d == BW'(DMA_MAX_BURST))) begin
                        state_q <= CPU_OWN;
                        gap_q   <= GW'(CPU_MIN_GAP);
                        stall_q <= 1'b0;
                        grant_q <= 1'b0;
                        owner_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= CPU_OWN;
                    stall_q <= 1'b0;
                    grant_q <= 1'b0;
                    owner_q <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_stall_o = stall_q;
    assign dma_grant_o = grant_q;
    assign owner_o     = owner_q;

    always_comb begin
        bus_address_o      = '0;
        bus_data_out_o     = '0;
        bus_data_strobes_o = '0;
        bus_read_o         = 1'b0;
        bus_write_o        = 1'b0;
        cpu_data_in_o      = '0;
        dma_data_in_o      = '0;
        dma_ack_o          = 1'b0;
        case (state_q)
            CPU_OWN: begin
                bus_address_o      = cpu_address_i;
                bus_data_out_o     = cpu_data_out_i;
                bus_data_strobes_o = cpu_data_strobes_i;
                bus_read_o         = cpu_read_i;
                bus_write_o        = cpu_write_i;
                cpu_data_in_o      = bus_data_in_i;
            end
            DMA_OWN: begin
                bus_address_o      = dma_address_i;
                bus_data_out_o     = dma_data_out_i;
                bus_data_strobes_o = dma_data_strobes_i;
                bus_read_o         = dma_req_i & ~dma_write_i;
                bus_write_o        = dma_req_i & dma_write_i;
                dma_ack_o          = dma_req_i;
                dma_data_in_o      = bus_data_in_i;
            end
            default: begin
                // HANDOVER: bus idle, both masters see zero read data.
            end
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
// Table-driven bench for bus_arbiter (DMA_MAX_BURST=4, CPU_MIN_GAP=2). Each
// table row gives the inputs for one clock cycle and the expected arbiter
// phase; the expected pin values for that phase are derived from the muxing
// rules and pushed to a scoreboard, then popped and compared mid-cycle.
// One row carries an asynchronous reset pulse in the middle of a DMA beat.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

    localparam int PC = 0;  // CPU owns bus
    localparam int PH = 1;  // handover
    localparam int PD = 2;  // DMA owns bus

    logic        clock = 1'b0;
    logic        reset_n;
    logic [29:0] cpu_address;
    logic [31:0] cpu_data_out;
    logic [3:0]  cpu_strb;
    logic        cpu_read, cpu_write;
    logic [31:0] cpu_data_in;
    logic        cpu_stall;
    logic        dma_req;
    logic [29:0] dma_address;
    logic [31:0] dma_data_out;
    logic [3:0]  dma_strb;
    logic        dma_write, dma_last;
    logic        dma_grant, dma_ack;
    logic [31:0] dma_data_in;
    logic [29:0] bus_address;
    logic [31:0] bus_data_out;
    logic [3:0]  bus_strb;
    logic        bus_read, bus_write;
    logic [31:0] bus_data_in;
    logic        owner;

    always #5 clock = ~clock;

    bus_arbiter #(.DMA_MAX_BURST(4), .CPU_MIN_GAP(2)) dut (
        .clock_i(clock), .reset_ni(reset_n),
        .cpu_address_i(cpu_address), .cpu_data_out_i(cpu_data_out),
        .cpu_data_strobes_i(cpu_strb), .cpu_read_i(cpu_read),
        .cpu_write_i(cpu_write), .cpu_data_in_o(cpu_data_in),
        .cpu_stall_o(cpu_stall), .dma_req_i(dma_req),
        .dma_address_i(dma_address), .dma_data_out_i(dma_data_out),
        .dma_data_strobes_i(dma_strb), .dma_write_i(dma_write),
        .dma_last_i(dma_last), .dma_grant_o(dma_grant), .dma_ack_o(dma_ack),
        .dma_data_in_o(dma_data_in), .bus_address_o(bus_address),
        .bus_data_out_o(bus_data_out), .bus_data_strobes_o(bus_strb),
        .bus_read_o(bus_read), .bus_write_o(bus_write),
        .bus_data_in_i(bus_data_in), .owner_o(owner)
    );

    typedef struct {
        bit req, wr, last, crd, cwr, rst;
        int ph;
    } vec_t;

    typedef struct {
        logic [29:0] addr;
        logic [31:0] dout;
        logic [3:0]  strb;
        logic        rd, wr, stall, grant, ack, own;
        logic [31:0] cdin, ddin;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   burst_q[$];
    int   total = 0;
    int   bad = 0;

    task automatic check(input string name, input int row,
                         input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s row=%0d got=%h want=%h", name, row, act, req);
        end
    endtask

    task automatic add(input bit req, input bit wr, input bit last,
                       input bit crd, input bit cwr, input int ph,
                       input bit rst = 1'b0);
        vec_t v;
        v.req = req; v.wr = wr; v.last = last;
        v.crd = crd; v.cwr = cwr; v.ph = ph; v.rst = rst;
        tbl.push_back(v);
    endtask

    // Expected pin values for a given phase and the currently driven inputs.
    function automatic exp_t model(input int ph);
        exp_t e;
        e = '{default: '0};
        if (ph == PC) begin
            e.addr = cpu_address; e.dout = cpu_data_out; e.strb = cpu_strb;
            e.rd = cpu_read; e.wr = cpu_write; e.cdin = bus_data_in;
        end else if (ph == PH) begin
            e.stall = 1'b1;
        end else begin
            e.addr = dma_address; e.dout = dma_data_out; e.strb = dma_strb;
            e.rd = dma_req & ~dma_write; e.wr = dma_req & dma_write;
            e.stall = 1'b1; e.grant = 1'b1; e.own = 1'b1;
            e.ack = dma_req; e.ddin = bus_data_in;
        end
        return e;
    endfunction

    task automatic compare_all(input int row, input exp_t e);
        check("bus_address", row, 32'(bus_address), 32'(e.addr));
        check("bus_data_out", row, bus_data_out, e.dout);
        check("bus_strobes", row, 32'(bus_strb), 32'(e.strb));
        check("bus_read", row, 32'(bus_read), 32'(e.rd));
        check("bus_write", row, 32'(bus_write), 32'(e.wr));
        check("cpu_stall", row, 32'(cpu_stall), 32'(e.stall));
        check("dma_grant", row, 32'(dma_grant), 32'(e.grant));
        check("dma_ack", row, 32'(dma_ack), 32'(e.ack));
        check("owner", row, 32'(owner), 32'(e.own));
        check("cpu_data_in", row, cpu_data_in, e.cdin);
        check("dma_data_in", row, dma_data_in, e.ddin);
        check("strobe_excl", row, 32'(bus_read & bus_write), 32'd0);
    endtask

    initial begin
        exp_t e;
        int   acks;
        int   prev_ph;
        int   exp_bursts[7] = '{3, 4, 4, 2, 1, 1, 4};

        // Post-reset sequence, then the 3-beat write burst.
        add(0,0,0,1,0,PC);                                   // 0: CPU read 0x100
        add(1,1,0,1,0,PC);                                   // 1: CPU wins, req seen
        add(1,1,0,0,0,PH);                                   // 2
        add(1,1,0,0,0,PD); add(1,1,0,0,0,PD); add(1,1,1,0,0,PD); // 3-5
        // 10-beat read request, truncated to 4+4+2.
        add(1,0,0,0,1,PC); add(1,0,0,1,0,PC); add(1,0,0,0,0,PH); // 6-8
        for (int i = 0; i < 4; i++) add(1,0,0,0,0,PD);         // 9-12
        add(1,0,0,1,0,PC); add(1,0,0,1,0,PC); add(1,0,0,0,0,PH); // 13-15
        for (int i = 0; i < 4; i++) add(1,0,0,0,0,PD);         // 16-19
        add(1,0,0,0,1,PC); add(1,0,0,1,0,PC); add(1,0,0,0,0,PH); // 20-22
        add(1,0,0,0,0,PD); add(1,0,1,0,0,PD);                 // 23-24
        // Request dropped during DMA_OWN after one beat.
        add(0,0,0,1,0,PC); add(1,1,0,0,0,PC); add(1,1,0,0,0,PH); // 25-27
        add(1,1,0,0,0,PD); add(0,1,0,0,0,PD); add(0,0,0,1,0,PC); // 28-30
        // Request dropped during HANDOVER.
        add(1,0,0,0,0,PC); add(0,0,0,0,0,PH); add(0,0,0,1,0,PC); // 31-33
        // Read burst interrupted by reset during beat 2.
        add(1,0,0,0,0,PC); add(1,0,0,0,0,PH); add(1,0,0,0,0,PD); // 34-36
        add(1,0,0,0,0,PD,1'b1);                               // 37: reset pulse
        add(1,0,0,0,0,PC); add(1,0,0,0,0,PH);                 // 38-39
        for (int i = 0; i < 4; i++) add(1,0,0,0,0,PD);         // 40-43
        add(0,0,0,1,0,PC); add(0,0,0,0,1,PC);                 // 44-45

        // Reset held with a DMA request pending: CPU mux, no grant.
        reset_n = 1'b0;
        dma_req = 1'b1; dma_write = 1'b0; dma_last = 1'b0;
        dma_address = 30'h800; dma_data_out = $urandom; dma_strb = 4'hF;
        cpu_read = 1'b1; cpu_write = 1'b0; cpu_address = 30'h40;
        cpu_data_out = $urandom; cpu_strb = 4'hF; bus_data_in = $urandom;
        @(posedge clock); #3;
        compare_all(-1, model(PC));
        @(posedge clock); #1;
        reset_n = 1'b1;

        acks = 0;
        prev_ph = PC;
        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            v = tbl[i];
            dma_req      = v.req;
            dma_write    = v.wr;
            dma_last     = v.last;
            dma_address  = 30'h800 + 30'(i);
            dma_data_out = $urandom;
            dma_strb     = 4'($urandom);
            cpu_read     = v.crd;
            cpu_write    = v.cwr;
            cpu_address  = (i == 0) ? 30'h40 : 30'($urandom);
            cpu_data_out = $urandom;
            cpu_strb     = 4'($urandom);
            bus_data_in  = $urandom;
            sb.push_back(model(v.ph));
            if (prev_ph == PD && v.ph != PD) begin
                burst_q.push_back(acks);
                acks = 0;
            end
            if (v.rst) begin
                #2;
                e = sb.pop_front();
                check("pre_rst_grant", i, 32'(dma_grant), 32'(e.grant));
                check("pre_rst_ack", i, 32'(dma_ack), 32'(e.ack));
                #1 reset_n = 1'b0;
                #1;
                check("rst_grant", i, 32'(dma_grant), 32'd0);
                check("rst_ack", i, 32'(dma_ack), 32'd0);
                check("rst_owner", i, 32'(owner), 32'd0);
                check("rst_stall", i, 32'(cpu_stall), 32'd0);
                $display("row %0d reset pulse grant=%0b ack=%0b", i, dma_grant, dma_ack);
                burst_q.push_back(acks);
                acks = 0;
                prev_ph = PC;
                @(posedge clock); #1;
                reset_n = 1'b1;
            end else begin
                #2;
                e = sb.pop_front();
                compare_all(i, e);
                if (dma_ack) acks++;
                $display("row %0d ph=%0d rd=%0b wr=%0b addr=%h stall=%0b grant=%0b ack=%0b",
                         i, v.ph, bus_read, bus_write, bus_address,
                         cpu_stall, dma_grant, dma_ack);
                prev_ph = v.ph;
                @(posedge clock); #1;
            end
        end

        check("burst_count", -1, 32'(burst_q.size()), 32'd7);
        for (int i = 0; i < 7; i++) begin
            if (i < burst_q.size())
                check("burst_len", i, 32'(burst_q[i]), 32'(exp_bursts[i]));
        end
        check("sb_empty", -1, 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
